// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller.
package keypad_pkg;

    // Scan controller states.
    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_e;

    // Hex code printed on each key, indexed [row][col].
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // True when exactly one row bit is set.
    function automatic logic is_onehot(input logic [3:0] s);
        return (s == 4'b0001) || (s == 4'b0010) || (s == 4'b0100) || (s == 4'b1000);
    endfunction

    // Row index of a one-hot row code; only meaningful when is_onehot(s).
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] s);
        logic [1:0] idx;
        idx = 2'd0;
        if (s[1]) idx = 2'd1;
        if (s[2]) idx = 2'd2;
        if (s[3]) idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one active-low column at a time, debounces
// press and release on the held column, and emits one key_valid pulse per press.
//
// There is no handshake: key_valid is a one-cycle strobe qualifying key_code,
// and the consumer must take it in that cycle (there is no ready/backpressure).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sense,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed,
    output state_e     state_dbg
);

    localparam int MAXC = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] SETTLE_LAST   = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] DEBOUNCE_LAST = CW'(DEBOUNCE_CYCLES - 1);

    state_e        state_q, state_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    col_n_q;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_pressed_q, key_pressed_d;
    logic [3:0]    row_mask;

    // Row code expected on sense while the latched key stays down.
    assign row_mask = 4'b0001 << row_idx_q;

    // State register; column drive is registered from the next column index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= SCAN;
            col_idx_q     <= 2'd0;
            row_idx_q     <= 2'd0;
            cnt_q         <= '0;
            col_n_q       <= 4'b1110;
            key_code_q    <= 4'h0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_idx_q     <= col_idx_d;
            row_idx_q     <= row_idx_d;
            cnt_q         <= cnt_d;
            col_n_q       <= ~(4'b0001 << col_idx_d);
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_pressed_q <= key_pressed_d;
        end
    end

    // Next-state logic: scan, press debounce, hold, release debounce.
    always_comb begin
        state_d       = state_q;
        col_idx_d     = col_idx_q;
        row_idx_d     = row_idx_q;
        cnt_d         = cnt_q;
        key_code_d    = key_code_q;
        key_valid_d   = 1'b0;
        key_pressed_d = key_pressed_q;

        unique case (state_q)
            SCAN: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    if (is_onehot(sense)) begin
                        row_idx_d = onehot_to_idx(sense);
                        state_d   = DB_PRESS;
                    end else begin
                        // No key or ambiguous multi-row: try the next column.
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DB_PRESS: begin
                if (sense == row_mask) begin
                    if (cnt_q == DEBOUNCE_LAST) begin
                        cnt_d         = '0;
                        key_code_d    = KEYMAP[row_idx_q][col_idx_q];
                        key_valid_d   = 1'b1;
                        key_pressed_d = 1'b1;
                        state_d       = HELD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    // Any disturbance abandons the press and resumes scanning.
                    cnt_d     = '0;
                    col_idx_d = col_idx_q + 2'd1;
                    state_d   = SCAN;
                end
            end

            HELD: begin
                if (sense != row_mask) begin
                    cnt_d   = '0;
                    state_d = DB_RELEASE;
                end
            end

            DB_RELEASE: begin
                if (sense == 4'b0000) begin
                    if (cnt_q == DEBOUNCE_LAST) begin
                        cnt_d         = '0;
                        key_pressed_d = 1'b0;
                        col_idx_d     = col_idx_q + 2'd1;
                        state_d       = SCAN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (sense == row_mask) begin
                    // Release bounce: the same key is still down.
                    cnt_d   = '0;
                    state_d = HELD;
                end else begin
                    // A different row or several rows: wait for all keys up.
                    cnt_d = '0;
                end
            end

            default: begin
                state_d = SCAN;
                cnt_d   = '0;
            end
        endcase
    end

    assign col_n       = col_n_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_pressed = key_pressed_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with a keypad pin model and a 2-flop row
// synchronizer/decoder in front of the DUT.
module tb_keypad_scanner;
    import keypad_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- keypad model + upstream synchronizer ----------------
    logic [15:0] keys;          // keys[r*4+c] = key at row r, column c is down
    logic [3:0]  row_pin_n;     // raw row pins, low when a key connects to a driven column
    logic [3:0]  sync1_n, sync2_n;
    logic [3:0]  act;
    logic [3:0]  sense;

    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_pressed;
    state_e      state_dbg;

    always_comb begin
        for (int r = 0; r < 4; r++)
            row_pin_n[r] = ~(|(keys[r*4 +: 4] & ~col_n));
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_n <= 4'b1111;
            sync2_n <= 4'b1111;
        end else begin
            sync1_n <= row_pin_n;
            sync2_n <= sync1_n;
        end
    end

    always_comb begin
        act = ~sync2_n;
        if ($countones(act) == 0)      sense = 4'b0000;
        else if ($countones(act) == 1) sense = act;
        else                           sense = 4'b1111;
    end

    keypad_scanner #(
        .SETTLE_CYCLES   (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sense       (sense),
        .col_n       (col_n),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_pressed (key_pressed),
        .state_dbg   (state_dbg)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [3:0] exp_q[$];
    logic       prev_kv = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            prev_kv = 1'b0;
        end else begin
            if (key_valid) begin
                check("kv_not_back_to_back", prev_kv, 1'b0);
                if (exp_q.size() == 0) check("kv_unexpected", key_valid, 1'b0);
                else                   check("key_code", key_code, exp_q.pop_front());
            end
            prev_kv = key_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic press(input int r, input int c);
        keys[r*4 + c] = 1'b1;
    endtask

    task automatic release_key(input int r, input int c);
        keys[r*4 + c] = 1'b0;
    endtask

    task automatic wait_kp(input logic val, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (key_pressed == val) break;
            @(negedge clk);
        end
        check(tag, key_pressed, val);
    endtask

    task automatic wait_state(input state_e st, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (state_dbg == st) break;
            @(negedge clk);
        end
        check(tag, state_dbg, st);
    endtask

    task automatic wait_col(input logic [3:0] v, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (col_n == v) break;
            @(negedge clk);
        end
        check(tag, col_n, v);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    logic [3:0] seq [5];
    logic [3:0] cur;

    initial begin
        reset = 1'b0;
        keys  = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_col_n", col_n, 4'b1110);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_pressed", key_pressed, 1'b0);
        check("rst_key_code", key_code, 4'h0);
        check("rst_state", state_dbg, SCAN);
        reset = 1'b1;

        // 1: idle scan, each column held four clocks
        wait_col(4'b1101, 10, "t1_first_step");
        seq[0] = 4'b1011; seq[1] = 4'b0111; seq[2] = 4'b1110; seq[3] = 4'b1101; seq[4] = 4'b1011;
        cur = 4'b1101;
        for (int k = 0; k < 5; k++) begin
            repeat (3) @(negedge clk);
            check("t1_hold", col_n, cur);
            @(negedge clk);
            check("t1_step", col_n, seq[k]);
            cur = seq[k];
        end

        // 2: clean press of r1c2 -> 6, release debounced after 8 idle samples
        press(1, 2);
        exp_q.push_back(4'h6);
        repeat (40) @(negedge clk);
        check("t2_pressed", key_pressed, 1'b1);
        check("t2_accepted", exp_q.size(), 0);
        release_key(1, 2);
        repeat (10) @(negedge clk);
        check("t2_still_pressed", key_pressed, 1'b1);
        @(negedge clk);
        check("t2_released", key_pressed, 1'b0);

        // 3: bouncy press of r3c1 -> 0, bounce during release debounce
        exp_q.push_back(4'h0);
        for (int b = 0; b < 3; b++) begin
            press(3, 1);
            repeat (3) @(negedge clk);
            release_key(3, 1);
            repeat (2) @(negedge clk);
        end
        press(3, 1);
        wait_kp(1'b1, 60, "t3_accept");
        repeat (5) @(negedge clk);
        check("t3_code_held", key_code, 4'h0);
        release_key(3, 1);
        repeat (6) @(negedge clk);
        check("t3_in_release_db", state_dbg, DB_RELEASE);
        press(3, 1);
        repeat (3) @(negedge clk);
        check("t3_back_to_held", state_dbg, HELD);
        check("t3_kp_during_bounce", key_pressed, 1'b1);
        repeat (3) @(negedge clk);
        release_key(3, 1);
        wait_kp(1'b0, 30, "t3_release");

        // 4: two rows on one column -> ignored until one is lifted
        press(0, 0);
        press(2, 0);
        repeat (40) @(negedge clk);
        check("t4_multi_ignored", key_pressed, 1'b0);
        release_key(2, 0);
        exp_q.push_back(4'h1);
        wait_kp(1'b1, 40, "t4_accept");
        release_key(0, 0);
        wait_kp(1'b0, 30, "t4_release");

        // 5: second key on another column is invisible while held, no rollover
        press(0, 3);
        exp_q.push_back(4'hA);
        wait_kp(1'b1, 40, "t5_accept_a");
        press(1, 0);
        repeat (30) @(negedge clk);
        check("t5_still_held", state_dbg, HELD);
        check("t5_kp", key_pressed, 1'b1);
        release_key(0, 3);
        exp_q.push_back(4'h4);
        wait_kp(1'b0, 30, "t5_release_a");
        wait_kp(1'b1, 40, "t5_accept_4");
        release_key(1, 0);
        wait_kp(1'b0, 30, "t5_release_4");

        // 6: reset during press debounce of r2c2, then re-accept 9
        press(2, 2);
        wait_state(DB_PRESS, 40, "t6_in_db_press");
        #1 reset = 1'b0;
        #1;
        check("t6_rst_col_n", col_n, 4'b1110);
        check("t6_rst_kv", key_valid, 1'b0);
        check("t6_rst_kp", key_pressed, 1'b0);
        check("t6_rst_state", state_dbg, SCAN);
        check("t6_rst_code", key_code, 4'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(4'h9);
        wait_kp(1'b1, 40, "t6_accept");
        release_key(2, 2);
        wait_kp(1'b0, 30, "t6_release");

        repeat (20) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
